// File: rtl/flash_reply_tx.sv
// Flash programming reply transmitter: one 60-byte status frame per erase_done/send_more request.
// Optional macro FLASH_REPLY_CHECKSUM_EN places the latched checksum in bytes 3,4 (zero otherwise).
module flash_reply_tx (
  input  logic        clock,
  input  logic        reset,
  input  logic        erase_done,
  input  logic        send_more,
  input  logic [15:0] checksum,
  input  logic [7:0]  board_type,
  input  logic [7:0]  code_version,
  input  logic        tx_grant,
  output logic        tx_request,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        erase_done_ACK,
  output logic        send_more_ACK
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] SEND     = 2'd2;
  localparam logic [1:0] ACK_WAIT = 2'd3;

  localparam logic [5:0] LAST_BYTE  = 6'd59;
  localparam logic [7:0] CODE_ERASE = 8'h03;
  localparam logic [7:0] CODE_MORE  = 8'h04;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [5:0] count;
  logic [5:0] count_nxt;
  logic       latch_en;
  logic       request_level;
  logic [7:0] code;
  logic [7:0] board;
  logic [7:0] version;
  logic [7:0] csum_hi;
  logic [7:0] csum_lo;
  logic [7:0] byte_nxt;

  function automatic logic [7:0] frame_byte(
    input logic [5:0] idx,
    input logic [7:0] c,
    input logic [7:0] hi,
    input logic [7:0] lo,
    input logic [7:0] bt,
    input logic [7:0] cv
  );
    case (idx)
      6'd0:    frame_byte = 8'hEF;
      6'd1:    frame_byte = 8'hFE;
      6'd2:    frame_byte = c;
      6'd3:    frame_byte = hi;
      6'd4:    frame_byte = lo;
      6'd5:    frame_byte = bt;
      6'd6:    frame_byte = cv;
      default: frame_byte = 8'h00;
    endcase
  endfunction

`ifdef FLASH_REPLY_CHECKSUM_EN
  logic [15:0] csum;

  // Checksum snapshot taken together with the rest of the frame fields
  always_ff @(posedge clock) begin
    if (reset) begin
      csum <= 16'h0000;
    end else if (latch_en) begin
      csum <= checksum;
    end else begin
      csum <= csum;
    end
  end

  assign csum_hi = csum[15:8];
  assign csum_lo = csum[7:0];
`else
  logic unused_checksum;
  assign unused_checksum = ^checksum;
  assign csum_hi = 8'h00;
  assign csum_lo = 8'h00;
`endif

  // The acknowledge handshake follows whichever request was latched
  always_comb begin
    if (code == CODE_ERASE) begin
      request_level = erase_done;
    end else begin
      request_level = send_more;
    end
  end

  // Next-state and byte-counter logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (erase_done || send_more) begin
          state_nxt = REQ;
          latch_en  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (tx_grant) begin
          state_nxt = SEND;
          count_nxt = 6'd0;
        end else begin
          state_nxt = REQ;
        end
      end
      SEND: begin
        if (count == LAST_BYTE) begin
          state_nxt = ACK_WAIT;
          count_nxt = 6'd0;
        end else begin
          count_nxt = count + 6'd1;
        end
      end
      ACK_WAIT: begin
        if (!request_level) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ACK_WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 6'd0;
      end
    endcase
  end

  // Outputs are registered from the next state, so byte 0 appears in the first SEND cycle
  always_comb begin
    if (state_nxt == SEND) begin
      byte_nxt = frame_byte(count_nxt, code, csum_hi, csum_lo, board, version);
    end else begin
      byte_nxt = 8'h00;
    end
  end

  // State, counter and frame-field registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      count   <= 6'd0;
      code    <= 8'h00;
      board   <= 8'h00;
      version <= 8'h00;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (latch_en) begin
        code    <= erase_done ? CODE_ERASE : CODE_MORE;
        board   <= board_type;
        version <= code_version;
      end else begin
        code    <= code;
        board   <= board;
        version <= version;
      end
    end
  end

  // Registered output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_request     <= 1'b0;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      tx_last        <= 1'b0;
      erase_done_ACK <= 1'b0;
      send_more_ACK  <= 1'b0;
    end else begin
      tx_request     <= (state_nxt == REQ) || (state_nxt == SEND);
      tx_data        <= byte_nxt;
      tx_valid       <= (state_nxt == SEND);
      tx_last        <= (state_nxt == SEND) && (count_nxt == LAST_BYTE);
      erase_done_ACK <= (state_nxt == ACK_WAIT) && (code == CODE_ERASE);
      send_more_ACK  <= (state_nxt == ACK_WAIT) && (code != CODE_ERASE);
    end
  end

endmodule

// File: doc/flash_reply_tx.md
FLASH_REPLY_TX -- requirements
Module: flash_reply_tx

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all logic on its positive edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: erase_done  input  1  flash erase-complete request from the flash programming block; level, held until acknowledged.
REQ-004 SHALL have port: send_more  input  1  next-block request from the flash programming block; level, held until acknowledged.
REQ-005 SHALL have port: checksum  input  16  running checksum of programmed bytes.
REQ-006 SHALL have port: board_type  input  8  board identifier, reply byte 5.
REQ-007 SHALL have port: code_version  input  8  firmware version, reply byte 6.
REQ-008 SHALL have port: tx_grant  input  1  Tx MAC arbiter grant; sampled only in REQ.
REQ-009 SHALL have port: tx_request  output  1  request for the Tx MAC.
REQ-010 SHALL have port: tx_data  output  8  reply byte.
REQ-011 SHALL have port: tx_valid  output  1  tx_data valid this cycle.
REQ-012 SHALL have port: tx_last  output  1  high with the final reply byte.
REQ-013 SHALL have port: erase_done_ACK  output  1  acknowledge for erase_done.
REQ-014 SHALL have port: send_more_ACK  output  1  acknowledge for send_more.

Function
REQ-015 SHALL implement states IDLE, REQ, SEND, ACK_WAIT.
REQ-016 IDLE: on erase_done=1 or send_more=1, SHALL latch code (0x03 erase, 0x04 send_more), checksum, board_type and code_version, then go to REQ; if both are high, erase_done SHALL win, and send_more SHALL be served on the next pass.
REQ-017 REQ: tx_request=1 from the first REQ cycle; on tx_grant=1, SHALL go to SEND.
REQ-018 SEND: SHALL emit 60 bytes on 60 consecutive cycles with tx_valid=1, using a 6-bit byte counter 0..59.
REQ-019 Frame: bytes 0,1 = 0xEF,0xFE; byte 2 = latched code; bytes 3,4 = checksum MSB,LSB (see REQ-031); byte 5 = board_type; byte 6 = code_version; bytes 7..59 = 0x00.
REQ-020 tx_last=1 only with byte 59.
REQ-021 tx_request SHALL stay 1 through byte 59, then drop to 0 on the next cycle; the next state is ACK_WAIT.
REQ-022 tx_grant changes during SEND SHALL be ignored; the frame always completes.
REQ-023 ACK_WAIT: SHALL assert the ACK matching the latched code.
REQ-024 The ACK SHALL be held until the matching request input is sampled 0; it deasserts the following cycle and the state returns to IDLE.
REQ-025 Minimum ACK width SHALL be 1 cycle, even if the request input is already low on entry.
REQ-026 A request deasserting during REQ or SEND SHALL NOT abort the frame.
REQ-027 Input changes after the IDLE latch SHALL NOT alter frame contents.
REQ-028 Both ACKs SHALL never be high in the same cycle.
REQ-029 When not in SEND, tx_data=0x00, tx_valid=0 and tx_last=0.

Reset
REQ-030 reset=1 SHALL, on the next edge, force IDLE, counter=0 and all outputs=0, including mid-frame: the frame is truncated with no tx_last, and a pending ACK is dropped.

Configuration
REQ-031 With macro FLASH_REPLY_CHECKSUM_EN defined, bytes 3,4 SHALL carry the latched checksum; undefined, bytes 3,4 SHALL be 0x00, the checksum latch SHALL be removed, and the checksum port SHALL remain but be unused.

Verification
REQ-032 send_more=1, checksum=0x1234, board_type=0x01, code_version=0x2A, grant 3 cycles later -> 60 bytes EF FE 04 12 34 01 2A 00..., tx_last on byte 59, send_more_ACK=1 until send_more low.
REQ-033 erase_done and send_more both rise in the same cycle -> erase frame (code 0x03) and erase_done_ACK first, then a second frame (code 0x04) and send_more_ACK; the ACKs never overlap.
REQ-034 tx_grant held 0 for 1000 cycles -> tx_request stays 1, tx_valid 0, no ACK; grant then given -> frame sent normally.
REQ-035 reset pulsed at byte 30 -> next cycle all outputs 0, no tx_last, no ACK; send_more still high -> a new full frame follows.
REQ-036 FLASH_REPLY_CHECKSUM_EN undefined, checksum=0xBEEF -> bytes 3,4 = 00 00; all other bytes unchanged.
